// File: rtl/jtcontra_gfx_linebuf_if.sv
// Renderer-side write bus of the scanline buffer: bank select, write strobe, {bank,addr} and pixel.
interface jtcontra_gfx_linebuf_if #(
    parameter int AW = 9,
    parameter int DW = 9
) ();
    logic          line;
    logic          scr_we;
    logic [AW:0]   line_addr;
    logic [DW-1:0] line_din;

    modport master (output line, output scr_we, output line_addr, output line_din);
    modport slave  (input  line, input  scr_we, input  line_addr, input  line_din);
endinterface

// File: rtl/jtcontra_gfx_linebuf.sv
// Double-buffered scanline store between the 007121 tilemap renderer and the colour mixer.
// Define JTCONTRA_LINEBUF_ERASE_EN to clear each location the clk after it is replayed.
module jtcontra_gfx_linebuf #(
    parameter int             AW       = 9,
    parameter int             DW       = 9,
    parameter logic [AW-1:0]  RD_START = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pxl_cen,
    input  logic                         LHBL,
    input  logic                         LVBL,
    jtcontra_gfx_linebuf_if.slave        wr,
    output logic [DW-1:0]                pxl,
    output logic [AW-1:0]                rd_addr
);

    logic [DW-1:0] mem [0:(2**(AW+1))-1];

    logic          last_LHBL;
    logic          hb_seen;
    logic          active;
    logic          rd_bank;
    logic [AW-1:0] rd_cnt;
    logic          rd_vld;
    logic          cen_d;
    logic [DW-1:0] ram_q;

    logic          line_start;
    logic          rd_en;
    logic [AW-1:0] rd_ptr;
    logic          rd_bsel;
    logic [AW:0]   rd_full;

    // hb_seen keeps a mid-line reset release from looking like a line start
    assign line_start = LHBL & ~last_LHBL & LVBL & hb_seen;
    assign rd_en      = pxl_cen & LHBL & LVBL & (active | line_start);
    assign rd_ptr     = line_start ? RD_START : rd_cnt;
    assign rd_bsel    = line_start ? wr.line : rd_bank;
    assign rd_full    = {rd_bsel, rd_ptr};
    assign rd_addr    = rd_cnt;

`ifdef JTCONTRA_LINEBUF_ERASE_EN
    logic          er_pend;
    logic [AW:0]   er_addr;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_LHBL <= 1'b0;
            hb_seen   <= 1'b0;
            active    <= 1'b0;
            rd_bank   <= 1'b0;
            rd_cnt    <= RD_START;
            rd_vld    <= 1'b0;
            cen_d     <= 1'b0;
            pxl       <= '0;
`ifdef JTCONTRA_LINEBUF_ERASE_EN
            er_pend   <= 1'b0;
            er_addr   <= '0;
`endif
        end else begin
            last_LHBL <= LHBL;
            if (!LHBL) hb_seen <= 1'b1;
            if (line_start) begin
                rd_bank <= wr.line;
                active  <= 1'b1;
            end
            if (rd_en)           rd_cnt <= rd_ptr + AW'(1);
            else if (line_start) rd_cnt <= RD_START;
            cen_d <= pxl_cen;
            if (pxl_cen) rd_vld <= rd_en;
            // blanked slots carry rd_vld=0 so the output goes to 0 with pixel alignment
            if (cen_d) pxl <= rd_vld ? ram_q : '0;
`ifdef JTCONTRA_LINEBUF_ERASE_EN
            er_pend <= rd_en;
            if (rd_en) er_addr <= rd_full;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr.scr_we) mem[wr.line_addr] <= wr.line_din;
`ifdef JTCONTRA_LINEBUF_ERASE_EN
        // renderer write to the same location wins over the erase
        if (er_pend && !(wr.scr_we && wr.line_addr == er_addr)) mem[er_addr] <= '0;
`endif
        if (rd_en) ram_q <= mem[rd_full];
    end

endmodule

// File: doc/jtcontra_gfx_linebuf.md
Name: jtcontra_gfx_linebuf

Overview:
- Double-buffered scanline store that sits directly downstream of the 007121 tilemap renderer.
- Captures the 9-bit pixels the renderer writes for the next line. Replays the previously completed line at pixel rate during the active display.
- Optionally erases each location after reading it, so the next fill starts transparent.
- Output feeds the colour-mixer/palette stage.

Parameters:
- AW, 9, address width within one bank; bank depth is 2^AW.
- DW, 9, pixel width: {scrwin, pal[3:0], colour[3:0]}.
- RD_START, 9'd0, read-counter value loaded at the start of each visible line.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low: reset acts on a rising clk edge while rst=0.
- pxl_cen  in  1  pixel clock enable; never asserted on two consecutive clk cycles.
- LHBL  in  1  horizontal blank, active-low (high = visible).
- LVBL  in  1  vertical blank, active-low.
- line  in  1  renderer's write-bank select.
- scr_we  in  1  renderer write strobe.
- line_addr  in  AW+1  {bank, address} from the renderer.
- line_din  in  DW  renderer pixel data.
- pxl  out  DW  pixel output to the mixer.
- rd_addr  out  AW  current read address, for debug and sync.

Behaviour:
- Storage:
  - One 2^(AW+1) x DW dual-port RAM.
  - Port A is write-only, owned by the renderer: on any clk with scr_we=1, mem[line_addr] <= line_din.
  - Port B is read/erase, owned by this block.
- Line start:
  - Detect the LHBL rising edge with a registered last_LHBL.
  - On the clk where LHBL=1 and last_LHBL=0, latch rd_bank <= line. This is the pre-toggle value, i.e. the bank just filled; the renderer toggles line one clk later.
  - On the same clk, load rd_cnt <= RD_START.
- Read pipeline:
  - On each clk with pxl_cen=1 and LHBL=1: issue a port B read at {rd_bank, rd_cnt}, then rd_cnt <= rd_cnt+1.
  - rd_cnt wraps modulo 2^AW (511 -> 0).
  - RAM data is registered on the next clk.
  - pxl updates on the following clk. pxl_cen-to-pxl latency is 2 clk.
- Blanking:
  - While LHBL=0 or LVBL=0, no reads are issued and rd_cnt holds.
  - pxl is forced to 0 at the pipeline output, with the same 2-clk alignment, so blank edges stay pixel-accurate.
- Erase (feature enabled):
  - The clk after a read, port B writes 0 to the same address. The pxl_cen spacing guarantees port B is free.
- Collisions:
  - If scr_we targets {rd_bank, addr} on the same clk as a port B read, the write lands and the read returns the old data.
  - If port A and a port B erase hit the same address on the same clk, port A wins.
- rd_addr = rd_cnt.
- Reset values: pxl=0, rd_cnt=RD_START, rd_bank=0, last_LHBL=0, erase pending=0. RAM contents are not cleared.
- Reset mid-line: the pipeline flushes and pxl=0 until the next LHBL rising edge reloads state.

Optional Feature:
- JTCONTRA_LINEBUF_ERASE_EN
- Defined: read-then-erase as above; unwritten locations read as 0 (transparent).
- Undefined: no port B writes; locations keep stale data until overwritten; port B is read-only.

Test Plan:
- Fill bank 0 with line=0: addr k <- 9'h100|k for k=0..319. Pulse LHBL rising, then pxl_cen every 2 clk. Required: pxl sequence 9'h100, 9'h101, ..., each appearing 2 clk after its pxl_cen.
- ERASE_EN: replay the same bank on the next line without refill. Required: pxl=0 for all 320 pixels. With the macro undefined, the original data repeats.
- LVBL=0 with LHBL toggling. Required: pxl stays 0, rd_cnt holds, rd_bank unchanged.
- RD_START=9'd508, with addrs 508..511 and 0..1 preloaded with 1..6. Required: pxl 1,2,3,4,5,6 (wrap verified).
- Renderer writes bank 1 while bank 0 is read on the same clk and the same low address. Required: the bank 0 output is unaffected and the bank 1 data is present on the next line.
- Assert rst=0 for 1 clk at pixel 100. Required: pxl=0 on the next clk and through the rest of the line; normal output resumes at the next LHBL rising edge from RD_START.
